// File: rtl/memory_test_controller.sv
// March-test master for the 32-byte banked memory: W0(P), R1(P)/W(~P) up, R2(~P) down.
// Optional first-fault capture is built when MEMTEST_FAULT_LOG_EN is defined.
module memory_test_controller #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rE,
    output logic                  mem_wE,
    input  logic [DATA_WIDTH-1:0] mem_dataOut,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] fail_count,
    output logic [ADDR_WIDTH-1:0] fail_address,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {
        IDLE, W0, R1_RD, R1_CMP, R1_WR, R2_RD, R2_CMP, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH+1:0] CNT_ONE   = (ADDR_WIDTH+2)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   pat_q, pat_d;
    logic [ADDR_WIDTH+1:0]   cnt_q, cnt_d;
    logic                    pass_q, pass_d;

    logic                    start_acc;
    logic                    cmp_en;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    mismatch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Read data is sampled on the edge that ends each CMP cycle.
    assign start_acc = (state_q == IDLE) && start;
    assign cmp_en    = (state_q == R1_CMP) || (state_q == R2_CMP);
    assign exp_data  = (state_q == R1_CMP) ? pat_q : ~pat_q;
    assign mismatch  = cmp_en && (mem_dataOut != exp_data);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        mem_rE   = 1'b0;
        mem_wE   = 1'b0;
        mem_data = '0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    cnt_d   = '0;
                    addr_d  = ADDR_ZERO;
                    state_d = W0;
                end
            end
            W0: begin
                mem_wE   = 1'b1;
                mem_data = pat_q;
                if (addr_q == ADDR_LAST) begin
                    addr_d  = ADDR_ZERO;
                    state_d = R1_RD;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            R1_RD: begin
                mem_rE  = 1'b1;
                state_d = R1_CMP;
            end
            R1_CMP: begin
                mem_rE  = 1'b1;
                if (mismatch) cnt_d = cnt_q + CNT_ONE;
                state_d = R1_WR;
            end
            R1_WR: begin
                mem_wE   = 1'b1;
                mem_data = ~pat_q;
                if (addr_q == ADDR_LAST) begin
                    state_d = R2_RD;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = R1_RD;
                end
            end
            R2_RD: begin
                mem_rE  = 1'b1;
                state_d = R2_CMP;
            end
            R2_CMP: begin
                mem_rE = 1'b1;
                if (mismatch) cnt_d = cnt_q + CNT_ONE;
                if (addr_q == ADDR_ZERO) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q - ADDR_ONE;
                    state_d = R2_RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                pass_d  = (cnt_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address = addr_q;
    assign busy        = (state_q != IDLE);
    assign pass        = pass_q;
    assign fail_count  = cnt_q;

`ifdef MEMTEST_FAULT_LOG_EN
    logic [ADDR_WIDTH-1:0] faddr_q;
    logic [DATA_WIDTH-1:0] fdata_q;

    // Only the first mismatch of a test is logged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (start_acc) begin
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (mismatch && (cnt_q == '0)) begin
            faddr_q <= addr_q;
            fdata_q <= mem_dataOut;
        end
    end

    assign fail_address = faddr_q;
    assign fail_data    = fdata_q;
`else
    logic unused_log;
    assign unused_log   = start_acc;
    assign fail_address = '0;
    assign fail_data    = '0;
`endif

endmodule

// File: doc/memory_test_controller.md
# memory_test_controller

Sequential test master for the 32-byte banked memory. It sits on the memory's initiator side, drives the data, address, read-enable and write-enable inputs, and samples the memory's data output. On a start request it runs a three-phase march test over every address and reports pass/fail, a mismatch count and, optionally, the first failing location.

## Interface
- ADDR_WIDTH, 5: memory address width; depth = 2^ADDR_WIDTH (32)
- DATA_WIDTH, 8: memory data width
- clock  input  1  rising-edge clock, shared with the memory
- reset  input  1  asynchronous, active-high; one clock, async active-high reset, fixed
- start  input  1  test request; sampled only in IDLE
- pattern  input  DATA_WIDTH  background pattern P; captured on the accepted start edge
- mem_data  output  DATA_WIDTH  write data to memory
- mem_address  output  ADDR_WIDTH  address to memory
- mem_rE  output  1  memory read enable
- mem_wE  output  1  memory write enable
- mem_dataOut  input  DATA_WIDTH  read data from memory
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at test end
- pass  output  1  high when the last completed test had zero mismatches
- fail_count  output  ADDR_WIDTH+2  mismatch count of the current or last test
- fail_address  output  ADDR_WIDTH  address of the first mismatch
- fail_data  output  DATA_WIDTH  data read at the first mismatch

## Operation
- States: IDLE, W0, R1_RD, R1_CMP, R1_WR, R2_RD, R2_CMP, DONE.
- **IDLE**
  - mem_rE and mem_wE are 0.
  - When start=1: capture P, clear fail_count and the fault log, address counter to 0, go to W0.
- **W0 (ascending)**
  - mem_wE=1, mem_data=P, mem_address=addr.
  - addr+1 each cycle. After address 2^ADDR_WIDTH-1, go to R1_RD with addr=0.
- **R1 (ascending, 3 cycles per address)**
  - R1_RD: mem_rE=1.
  - R1_CMP: mem_rE=1, mem_address held. Sample mem_dataOut and compare with P.
  - R1_WR: mem_wE=1, mem_data=~P. Then addr+1.
  - After the last address, go to R2_RD with addr=2^ADDR_WIDTH-1.
- **R2 (descending, 2 cycles per address)**
  - R2_RD: mem_rE=1.
  - R2_CMP: mem_rE=1. Sample and compare with ~P. Then addr-1.
  - After address 0, go to DONE.
- **DONE** (one cycle)
  - done=1.
  - pass latched as (fail_count==0).
  - Then return to IDLE.
- **Mismatch:** fail_count increments by 1. Width ADDR_WIDTH+2 holds the maximum of 2·2^ADDR_WIDTH without wrap.
- **Signal rules**
  - mem_rE and mem_wE are never both 1.
  - mem_data is 0 whenever mem_wE=0.
  - Address counter arithmetic is modulo 2^ADDR_WIDTH. Terminal detection uses the explicit end values given above, not wrap-around.
- **start while busy:** ignored. pattern changes after capture have no effect.

## Timing
- **Reset values:** mem_data=0, mem_address=0, mem_rE=0, mem_wE=0, busy=0, done=0, pass=0, fail_count=0, fail_address=0, fail_data=0. State=IDLE.
- **Reset mid-test:** all outputs return to the reset values asynchronously, and memory strobes drop immediately. Memory contents are left as-is. The next start runs a full test.
- **Start:** the edge that samples start=1 enters W0. busy is high from the next cycle.
- **Latency at depth 32:**
  - W0 = 32 cycles, R1 = 96 cycles, R2 = 64 cycles.
  - done is high in cycle 193 after the start edge. busy falls in cycle 194.
- **Read timing:** the memory read is given two cycles with address and rE stable. mem_dataOut is sampled at the end of the CMP cycle. This covers both combinational and registered memory output.
- **Result hold:** pass, fail_count and the fault log hold until the next accepted start.

## Configuration
- MEMTEST_FAULT_LOG_EN defined: on the first mismatch of a test, capture fail_address=mem_address and fail_data=mem_dataOut. Later mismatches do not overwrite them.
- Not defined: fail_address and fail_data are tied to 0, and no capture registers are built. fail_count and pass are unaffected.

## Test plan
- **Fault-free run:** fault-free behavioral memory, pattern=8'hA5, start pulse. Required response:
  - W0 writes A5 to addresses 0..31.
  - R1 writes 5A.
  - done in cycle 193, pass=1, fail_count=0.
- **Stuck bit:** bit0 stuck-at-1 at address 17, pattern=8'h00. Required response:
  - fail_count=1, pass=0.
  - With MEMTEST_FAULT_LOG_EN: fail_address=17, fail_data=8'h01.
- **Dead cell:** address 31 ignores writes and reads 8'h00, pattern=8'h5A. Required response:
  - fail_count=2.
  - First logged fail is address 31 with data 8'h00.
- **Start while busy:** start pulse at cycle 40 of a test, with pattern=8'hFF. Required response: ignored; the test completes in cycle 193 using the original pattern.
- **Reset mid-run:** reset asserted at cycle 50. Required response:
  - Strobes and busy go to 0 immediately, with no clock edge.
  - A new start after reset gives done in cycle 193 and pass=1.
- **Protocol monitor, all runs:**
  - mem_rE and mem_wE are never both 1.
  - R2 addresses are strictly descending 31..0.
  - address is stable across each RD/CMP pair.
